// File: rtl/fifo_pair_packer.sv
// Read-side drain for the 1-write/2-read FIFO: pops 0/1/2 entries per cycle and packs them into
// one registered 2*WIDTH beat. Optional `flush_i` port exists only when PACKER_FLUSH_EN is defined.
module fifo_pair_packer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               softreset_i,
    input  logic [15:0]        count_i,
    input  logic [2*WIDTH-1:0] fifo_dout_i,
    output logic [1:0]         reads_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] out_data_o,
    output logic [1:0]         out_mask_o
`ifdef PACKER_FLUSH_EN
    ,
    input  logic               flush_i
`endif
);

    localparam logic [7:0] TimeoutLim = 8'(TIMEOUT);

    logic               out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]         out_mask_q, out_mask_d;
    logic [7:0]         wt_q, wt_d;

    logic clear;
    logic slot_free;
    logic flush_w;
    logic pop_pair;
    logic pop_lone;

`ifdef PACKER_FLUSH_EN
    assign flush_w = flush_i;
`else
    assign flush_w = 1'b0;
`endif

    always_comb begin
        clear       = rst_i || softreset_i;
        slot_free   = !out_valid_q || out_ready_i;
        // No pops during reset: the slot would discard them and the entries would be lost.
        pop_pair    = !clear && slot_free && (count_i >= 16'd2);
        pop_lone    = !clear && slot_free && (count_i == 16'd1) &&
                      ((wt_q >= TimeoutLim) || flush_w);

        reads_o     = 2'd0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_mask_d  = out_mask_q;
        wt_d        = wt_q;

        if (pop_pair) begin
            reads_o     = 2'd2;
            out_valid_d = 1'b1;
            out_data_d  = fifo_dout_i;
            out_mask_d  = 2'b11;
        end else if (pop_lone) begin
            reads_o     = 2'd1;
            out_valid_d = 1'b1;
            out_data_d  = {{WIDTH{1'b0}}, fifo_dout_i[WIDTH-1:0]};
            out_mask_d  = 2'b01;
        end else if (slot_free) begin
            out_valid_d = 1'b0;
        end

        // Timer keeps counting while blocked so a timed-out entry leaves on the first free cycle.
        if (pop_pair || pop_lone) begin
            wt_d = 8'd0;
        end else if (count_i == 16'd1) begin
            wt_d = (wt_q < TimeoutLim) ? wt_q + 8'd1 : wt_q;
        end else begin
            wt_d = 8'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mask_q  <= 2'b00;
            wt_q        <= 8'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mask_q  <= out_mask_d;
            wt_q        <= wt_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_mask_o  = out_mask_q;

endmodule

// File: tb/tb_fifo_pair_packer.sv
// Self-checking bench for fifo_pair_packer: a queue-backed FIFO and a beat-level model drive
// directed scenarios followed by randomized traffic, compared every cycle.
module tb_fifo_pair_packer;

    localparam int unsigned W  = 16;
    localparam int unsigned TO = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           softreset;
    logic [15:0]    count;
    logic [2*W-1:0] fifo_dout;
    logic [1:0]     reads;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_data;
    logic [1:0]     out_mask;
    logic           flush;

    fifo_pair_packer #(
        .WIDTH  (W),
        .TIMEOUT(TO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .softreset_i(softreset),
        .count_i    (count),
        .fifo_dout_i(fifo_dout),
        .reads_o    (reads),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_mask_o (out_mask)
`ifdef PACKER_FLUSH_EN
        ,
        .flush_i    (flush)
`endif
    );

    always #5 clk = ~clk;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    // Bench-side FIFO contents, oldest first.
    logic [W-1:0] fq[$];

    // Expected output slot and how long the current lone entry has been waiting.
    logic           m_valid = 1'b0;
    logic [2*W-1:0] m_data  = '0;
    logic [1:0]     m_mask  = 2'b00;
    int             m_wait  = 0;
    logic [1:0]     last_reads;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock cycle: present FIFO window, check outputs, then advance FIFO and model.
    task automatic step();
        int           cnt;
        logic [W-1:0] e0, e1;
        logic         free;
        logic [1:0]   er;
        logic         in_rst;
        cnt       = fq.size();
        e0        = (cnt > 0) ? fq[0] : '0;
        e1        = (cnt > 1) ? fq[1] : '0;
        count     = 16'(cnt);
        fifo_dout = {e1, e0};
        #1;
        in_rst = rst || softreset;
        free   = !m_valid || out_ready;
        er     = 2'd0;
        if (!in_rst && free) begin
            if (cnt >= 2) er = 2'd2;
            else if (cnt == 1 && (m_wait >= int'(TO) || flush)) er = 2'd1;
        end
        last_reads = reads;
        if (!in_rst) chk("reads", 64'(reads), 64'(er));
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_data", 64'(out_data), 64'(m_data));
        chk("out_mask", 64'(out_mask), 64'(m_mask));
        @(posedge clk);
        if (in_rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_mask  = 2'b00;
            m_wait  = 0;
        end else if (er == 2'd2) begin
            void'(fq.pop_front());
            void'(fq.pop_front());
            m_valid = 1'b1;
            m_data  = {e1, e0};
            m_mask  = 2'b11;
            m_wait  = 0;
        end else if (er == 2'd1) begin
            void'(fq.pop_front());
            m_valid = 1'b1;
            m_data  = {{W{1'b0}}, e0};
            m_mask  = 2'b01;
            m_wait  = 0;
        end else begin
            if (free) m_valid = 1'b0;
            m_wait = (cnt == 1) ? m_wait + 1 : 0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [2*W-1:0] held;
        rst       = 1'b1;
        softreset = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        count     = '0;
        fifo_dout = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state.
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_mask", 64'(out_mask), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        step();
        chk("rst_reads", 64'(last_reads), 64'd0);

        // Burst of six entries: three back-to-back pair beats.
        for (int i = 0; i < 6; i++) fq.push_back(16'hA000 + 16'(i));
        step();
        chk("burst_r0", 64'(last_reads), 64'd2);
        chk("burst_b0", 64'(out_data), 64'h A001_A000);
        chk("burst_m0", 64'(out_mask), 64'd3);
        step();
        chk("burst_r1", 64'(last_reads), 64'd2);
        chk("burst_b1", 64'(out_data), 64'h A003_A002);
        step();
        chk("burst_r2", 64'(last_reads), 64'd2);
        chk("burst_b2", 64'(out_data), 64'h A005_A004);
        step();
        chk("burst_idle", 64'(out_valid), 64'd0);

        // Lone entry: four idle cycles, pop on the fifth.
        fq.push_back(16'h0BEE);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("lone_wait", 64'(last_reads), 64'd0);
        end
        step();
        chk("lone_pop", 64'(last_reads), 64'd1);
        chk("lone_data", 64'(out_data), 64'h0000_0BEE);
        chk("lone_mask", 64'(out_mask), 64'd1);

        // Partner arrives before the timeout: one pair beat, no half beat.
        fq.push_back(16'h1111);
        step();
        step();
        fq.push_back(16'h2222);
        step();
        chk("rescue_reads", 64'(last_reads), 64'd2);
        chk("rescue_data", 64'(out_data), 64'h2222_1111);
        chk("rescue_mask", 64'(out_mask), 64'd3);

        // Backpressure with four entries queued behind a held beat.
        for (int i = 0; i < 6; i++) fq.push_back(16'hC000 + 16'(i));
        step();
        out_ready = 1'b0;
        held      = out_data;
        chk("bp_held", 64'(held), 64'h C001_C000);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_reads", 64'(last_reads), 64'd0);
            chk("bp_stable", 64'(out_data), 64'(held));
        end
        out_ready = 1'b1;
        step();
        chk("bp_release", 64'(last_reads), 64'd2);
        chk("bp_next", 64'(out_data), 64'h C003_C002);

        // Reset while a beat is stalled.
        out_ready = 1'b0;
        fq.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_mask", 64'(out_mask), 64'd0);
        step();
        chk("mid_rst_reads", 64'(last_reads), 64'd0);
        out_ready = 1'b1;
        step();

`ifdef PACKER_FLUSH_EN
        fq.push_back(16'h0F1F);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_reads", 64'(last_reads), 64'd1);
        chk("flush_valid", 64'(out_valid), 64'd1);
        chk("flush_data", 64'(out_data), 64'h0000_0F1F);
`endif

        // Randomized traffic with varying push density.
        for (int i = 0; i < 3000; i++) begin
            int seg;
            seg       = (i / 300) % 3;
            out_ready = ($urandom_range(0, 3) != 0);
            softreset = ($urandom_range(0, 199) == 0);
`ifdef PACKER_FLUSH_EN
            flush = ($urandom_range(0, 15) == 0);
`endif
            if (fq.size() < 20) begin
                if (seg == 0) begin
                    int n;
                    n = $urandom_range(0, 3);
                    for (int k = 0; k < n; k++) fq.push_back(W'($urandom));
                end else if (seg == 1) begin
                    if ($urandom_range(0, 9) == 0) fq.push_back(W'($urandom));
                end else begin
                    if ($urandom_range(0, 2) == 0) fq.push_back(W'($urandom));
                end
            end
            step();
        end
        softreset = 1'b0;
        flush     = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
